// File: rtl/wam_pkg.sv
// wam_pkg: shared state encodings, LFSR polynomial, level clamp and popcount helper
package wam_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [3:0] LVL_MAX = 4'd9;
  function automatic logic [4:0] pop16(input logic [15:0] v);
    pop16 = '0;
    for (int j = 0; j < 16; j++) pop16 += {4'd0, v[j]};
  endfunction
endpackage

// File: rtl/wam_if.sv
// wam_if: player controls in, game status out
interface wam_if #(
  parameter int N_HOLES = 8,
  parameter int SCORE_W = 12
);
  logic start;
  logic pse;
  logic [3:0] level;
  logic [N_HOLES-1:0] tap;
  logic [N_HOLES-1:0] holes;
  logic [SCORE_W-1:0] score;
  logic [7:0] time_left;
  logic [1:0] state;
  logic hit_p;
  modport master (output start, pse, level, tap, input holes, score, time_left, state, hit_p);
  modport slave (input start, pse, level, tap, output holes, score, time_left, state, hit_p);
endinterface

// File: rtl/wam_hole.sv
// wam_hole: one hole's presence flag and lifetime countdown
module wam_hole #(
  parameter int AGE_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             tick,
  input  logic             spawn,
  input  logic             hit,
  input  logic             clear_all,
  input  logic [AGE_W-1:0] age_load,
  output logic             active
);
  logic [AGE_W-1:0] age;
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      active <= 1'b0;
      age <= '0;
    end else if (clear_all || hit) begin
      active <= 1'b0;
    end else if (spawn) begin
      active <= 1'b1;
      age <= age_load;
    end else if (tick && active) begin
      active <= age != AGE_W'(1);
      age <= age - 1'b1;
    end
  end
endmodule

// File: rtl/wam_core.sv
// wam_core: whack-a-mole engine with round timer, LFSR spawner, tap sync and scoring
module wam_core
  import wam_pkg::*;
#(
  parameter int          N_HOLES     = 8,
  parameter int          TICK_DIV    = 524288,
  parameter int          ROUND_TICKS = 60,
  parameter int          AGE_W       = 4,
  parameter int          MAX_AGE     = 12,
  parameter int          SCORE_W     = 12,
  parameter int          MISS_PEN    = 1,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic  clk,
  input logic  clr_n,
  wam_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SMAX = (1 << SCORE_W) - 1;
  state_t st;
  logic [15:0] lfsr;
  logic [PW-1:0] presc;
  logic [N_HOLES+1:0] s1, s2, s3, edge_p;
  logic [N_HOLES-1:0] holes, hit_v, miss_v;
  logic [SCORE_W-1:0] score;
  logic [7:0] time_left;
  logic [AGE_W-1:0] age_load;
  logic [3:0] lvl;
  logic [4:0] idx;
  logic hit_p, play, tick, rnd_ok, restart, last_tick, clear_all, start_p, pse_p;
  int sum;
  assign edge_p = s2 & ~s3;
  assign start_p = edge_p[N_HOLES+1];
  assign pse_p = edge_p[N_HOLES];
  assign play = st == ST_PLAY;
  assign tick = play && presc == PW'(TICK_DIV - 1);
  assign restart = start_p && (st == ST_IDLE || st == ST_OVER);
  assign last_tick = tick && time_left == 8'd1;
  assign clear_all = restart || last_tick;
  assign lvl = bus.level > LVL_MAX ? LVL_MAX : bus.level;
  assign rnd_ok = {1'b0, lfsr[15:8]} < 9'd64 + {1'b0, lvl, 4'd0};
  assign idx = 5'({1'b0, lfsr[7:4]} % 5'(N_HOLES));
  assign age_load = AGE_W'(MAX_AGE) - AGE_W'(lvl);
  assign hit_v = edge_p[N_HOLES-1:0] & holes & {N_HOLES{play}};
  assign miss_v = edge_p[N_HOLES-1:0] & ~holes & {N_HOLES{play && MISS_PEN != 0}};
  assign sum = int'(score) + int'(pop16(16'(hit_v))) - int'(pop16(16'(miss_v)));
  for (genvar i = 0; i < N_HOLES; i++) begin : g_hole
    wam_hole #(.AGE_W(AGE_W)) u_hole (
      .clk      (clk),
      .clr_n    (clr_n),
      .tick     (tick),
      .spawn    (tick && rnd_ok && idx == 5'(i) && !holes[i]),
      .hit      (hit_v[i]),
      .clear_all(clear_all),
      .age_load (age_load),
      .active   (holes[i])
    );
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      st <= ST_IDLE;
      score <= '0;
      time_left <= '0;
      hit_p <= 1'b0;
      presc <= '0;
      lfsr <= SEED == 16'h0 ? 16'h1 : SEED;
      {s3, s2, s1} <= '0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0);
      {s3, s2, s1} <= {s2, s1, bus.start, bus.pse, bus.tap};
      hit_p <= |hit_v;
      if (restart) begin
        st <= ST_PLAY;
        score <= '0;
        time_left <= 8'(ROUND_TICKS);
        presc <= '0;
      end else if (play) begin
        score <= sum < 0 ? '0 : sum > SMAX ? SCORE_W'(SMAX) : SCORE_W'(sum);
        presc <= tick ? '0 : presc + 1'b1;
        time_left <= tick ? time_left - 8'd1 : time_left;
        st <= last_tick ? ST_OVER : pse_p && !start_p ? ST_PAUSE : ST_PLAY;
      end else if (st == ST_PAUSE && pse_p && !start_p) begin
        st <= ST_PLAY;
      end
    end
  end
  assign bus.holes = holes;
  assign bus.score = score;
  assign bus.time_left = time_left;
  assign bus.state = st;
  assign bus.hit_p = hit_p;
endmodule
